// File: rtl/tx_anc_sync_gen.sv
// ANC transmit burst generator: sync/acknowledge handshake on GPIO, guard gap, then AXI-S DDS phase stream.
// Optional TX_ANC_GPIO_SYNC_FF_EN adds a two-flop synchronizer ahead of the GPIO input register.
module tx_anc_sync_gen #(
  parameter int unsigned                PHASE_WIDTH    = 24,
  parameter int unsigned                NSYMB_WIDTH    = 16,
  parameter int unsigned                NSYMB          = 512,
  parameter int unsigned                NSIG           = 16384,
  parameter logic [PHASE_WIDTH-1:0]     START_PH       = '0,
  parameter logic [PHASE_WIDTH-1:0]     START_PH_INC   = PHASE_WIDTH'(4096),
  parameter logic [PHASE_WIDTH-1:0]     DPH_INC        = PHASE_WIDTH'(16384),
  parameter int unsigned                SYNC_SIG_N     = 8192,
  parameter int unsigned                GPIO_REG_WIDTH = 12,
  parameter logic [GPIO_REG_WIDTH-1:0]  SYNC_OUT_MASK  = GPIO_REG_WIDTH'(12'h004),
  parameter logic [GPIO_REG_WIDTH-1:0]  ACK_IN_MASK    = GPIO_REG_WIDTH'(12'h001)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      sync_err,
  input  logic [GPIO_REG_WIDTH-1:0] gpio_in,
  output logic [GPIO_REG_WIDTH-1:0] gpio_out,
  output logic [GPIO_REG_WIDTH-1:0] gpio_ddr,
  output logic [PHASE_WIDTH-1:0]    phase_tdata,
  output logic                      phase_tvalid,
  input  logic                      phase_tready,
  output logic                      phase_tlast,
  output logic [1:0]                tx_state,
  output logic [NSYMB_WIDTH-1:0]    symb_idx
);

  localparam int unsigned CW = $clog2(SYNC_SIG_N + 1);
  localparam logic [CW-1:0]          CNT_LAST  = CW'(SYNC_SIG_N);
  localparam logic [PHASE_WIDTH-1:0] NSIG_LAST = PHASE_WIDTH'(NSIG);
  localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST = NSYMB_WIDTH'(NSYMB - 1);
  localparam logic                   TLAST_AT_FIRST = (NSIG == 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SYNC   = 2'b01,
    GUARD  = 2'b10,
    STREAM = 2'b11
  } state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic                      ack_seen, ack_seen_nxt;
  logic [PHASE_WIDTH-1:0]    samp_cnt, samp_cnt_nxt, samp_inc;
  logic [PHASE_WIDTH-1:0]    ph_inc, ph_inc_nxt;
  logic [PHASE_WIDTH-1:0]    tdata_nxt;
  logic                      tvalid_nxt, tlast_nxt;
  logic [NSYMB_WIDTH-1:0]    symb_nxt;
  logic                      busy_nxt, done_nxt, sync_err_nxt;
  logic [GPIO_REG_WIDTH-1:0] gpio_out_nxt;
  logic [GPIO_REG_WIDTH-1:0] gpio_in_q;
  logic                      ack_now;

  assign gpio_ddr = SYNC_OUT_MASK;
  assign tx_state = state;

`ifdef TX_ANC_GPIO_SYNC_FF_EN
  logic [GPIO_REG_WIDTH-1:0] gpio_meta, gpio_sync;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
      gpio_in_q <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      gpio_in_q <= gpio_sync;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gpio_in_q <= '0;
    else        gpio_in_q <= gpio_in;
  end
`endif

  assign ack_now  = |(gpio_in_q & ACK_IN_MASK);
  assign samp_inc = samp_cnt + PHASE_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ack_seen     <= 1'b0;
      samp_cnt     <= '0;
      ph_inc       <= START_PH_INC;
      phase_tdata  <= START_PH;
      phase_tvalid <= 1'b0;
      phase_tlast  <= 1'b0;
      symb_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sync_err     <= 1'b0;
      gpio_out     <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ack_seen     <= ack_seen_nxt;
      samp_cnt     <= samp_cnt_nxt;
      ph_inc       <= ph_inc_nxt;
      phase_tdata  <= tdata_nxt;
      phase_tvalid <= tvalid_nxt;
      phase_tlast  <= tlast_nxt;
      symb_idx     <= symb_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      sync_err     <= sync_err_nxt;
      gpio_out     <= gpio_out_nxt;
    end
  end

  // Every output is registered, so each transition also loads the value the next state presents.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ack_seen_nxt = ack_seen;
    samp_cnt_nxt = samp_cnt;
    ph_inc_nxt   = ph_inc;
    tdata_nxt    = phase_tdata;
    tvalid_nxt   = phase_tvalid;
    tlast_nxt    = phase_tlast;
    symb_nxt     = symb_idx;
    done_nxt     = 1'b0;
    sync_err_nxt = sync_err;
    gpio_out_nxt = gpio_out;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = SYNC;
          sync_err_nxt = 1'b0;
          cnt_nxt      = CW'(1);
          ack_seen_nxt = 1'b0;
          gpio_out_nxt = SYNC_OUT_MASK;
        end
      end
      SYNC: begin
        if (ack_now) ack_seen_nxt = 1'b1;
        if (cnt == CNT_LAST) begin
          gpio_out_nxt = '0;
          if (ack_seen || ack_now) begin
            state_nxt = GUARD;
            cnt_nxt   = CW'(1);
          end else begin
            state_nxt    = IDLE;
            sync_err_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GUARD: begin
        if (cnt == CNT_LAST) begin
          state_nxt    = STREAM;
          tdata_nxt    = START_PH;
          ph_inc_nxt   = START_PH_INC;
          samp_cnt_nxt = PHASE_WIDTH'(1);
          symb_nxt     = '0;
          tvalid_nxt   = 1'b1;
          tlast_nxt    = TLAST_AT_FIRST;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STREAM: begin
        if (phase_tvalid && phase_tready) begin
          if (!phase_tlast) begin
            tdata_nxt    = phase_tdata + ph_inc;
            samp_cnt_nxt = samp_inc;
            tlast_nxt    = (samp_inc == NSIG_LAST);
          end else if (symb_idx != SYMB_LAST) begin
            tdata_nxt    = START_PH;
            ph_inc_nxt   = ph_inc + DPH_INC;
            symb_nxt     = symb_idx + NSYMB_WIDTH'(1);
            samp_cnt_nxt = PHASE_WIDTH'(1);
            tlast_nxt    = TLAST_AT_FIRST;
          end else begin
            state_nxt    = IDLE;
            done_nxt     = 1'b1;
            tvalid_nxt   = 1'b0;
            tlast_nxt    = 1'b0;
            tdata_nxt    = START_PH;
            ph_inc_nxt   = START_PH_INC;
            symb_nxt     = '0;
            samp_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_tx_anc_sync_gen.sv
// Bench for tx_anc_sync_gen: timeline model of the burst plus literal beat tables for directed scenarios.
module tb_tx_anc_sync_gen;

  localparam int N     = 8;
  localparam int NSYMB = 3;
  localparam int NSIG  = 4;
  localparam int TOTAL = NSYMB * NSIG;
  localparam longint INC   = 100;
  localparam longint INC_W = 64'hC00000;
  localparam longint DPH   = 50;

  localparam logic [23:0] EXP_B [12] = '{24'd0, 24'd100, 24'd200, 24'd300,
                                         24'd0, 24'd150, 24'd300, 24'd450,
                                         24'd0, 24'd200, 24'd400, 24'd600};
  localparam logic [23:0] EXP_W [4]  = '{24'h000000, 24'hC00000, 24'h800000, 24'h400000};

  logic        clk, reset, start, tready;
  logic [11:0] gpio_in;

  logic        busy, done, sync_err, tvalid, tlast;
  logic [11:0] gpio_out, gpio_ddr;
  logic [23:0] tdata;
  logic [1:0]  tx_state;
  logic [15:0] symb_idx;

  logic        w_busy, w_done, w_sync_err, w_tvalid, w_tlast;
  logic [11:0] w_gpio_out, w_gpio_ddr;
  logic [23:0] w_tdata;
  logic [1:0]  w_tx_state;
  logic [15:0] w_symb_idx;

  tx_anc_sync_gen #(
    .NSYMB(NSYMB), .NSIG(NSIG), .SYNC_SIG_N(N),
    .START_PH(24'd0), .START_PH_INC(24'd100), .DPH_INC(24'd50)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .sync_err(sync_err),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_ddr(gpio_ddr),
    .phase_tdata(tdata), .phase_tvalid(tvalid), .phase_tready(tready), .phase_tlast(tlast),
    .tx_state(tx_state), .symb_idx(symb_idx)
  );

  tx_anc_sync_gen #(
    .NSYMB(NSYMB), .NSIG(NSIG), .SYNC_SIG_N(N),
    .START_PH(24'd0), .START_PH_INC(24'hC00000), .DPH_INC(24'd50)
  ) dut_w (
    .clk(clk), .reset(reset), .start(start), .busy(w_busy), .done(w_done), .sync_err(w_sync_err),
    .gpio_in(gpio_in), .gpio_out(w_gpio_out), .gpio_ddr(w_gpio_ddr),
    .phase_tdata(w_tdata), .phase_tvalid(w_tvalid), .phase_tready(tready), .phase_tlast(w_tlast),
    .tx_state(w_tx_state), .symb_idx(w_symb_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a burst is a timeline; el counts cycles since start, beats counts accepted samples.
  bit active, ack_m, serr_m, done_m;
  int el, beats;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 0; el <= 0; beats <= 0; serr_m <= 0; done_m <= 0; ack_m <= 0;
    end else begin
      done_m <= 0;
      if (!active) begin
        if (start) begin
          active <= 1; el <= 1; serr_m <= 0; ack_m <= ((gpio_in & 12'h001) != 0);
        end
      end else if (el <= N) begin
        if (el == N && !ack_m) begin
          active <= 0; serr_m <= 1;
        end else el <= el + 1;
      end else if (el <= 2 * N) begin
        el <= el + 1;
      end else if (tready) begin
        if (beats == TOTAL - 1) begin
          active <= 0; done_m <= 1; beats <= 0;
        end else beats <= beats + 1;
      end
    end
  end

  function automatic int m_state();
    if (!active)        return 0;
    else if (el <= N)   return 1;
    else if (el <= 2*N) return 2;
    else                return 3;
  endfunction

  function automatic longint m_phase(input longint inc, input int b);
    longint v;
    v = longint'(b % NSIG) * (inc + longint'(b / NSIG) * DPH);
    return v & 64'hFFFFFF;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      int st;
      st = m_state();
      check("tx_state", tx_state, st);
      check("busy", busy, active);
      check("done", done, done_m);
      check("sync_err", sync_err, serr_m);
      check("gpio_out", gpio_out, (st == 1) ? 12'h004 : 12'h000);
      check("tvalid", tvalid, st == 3);
      check("symb_idx", symb_idx, (st == 3) ? beats / NSIG : 0);
      check("w_tvalid", w_tvalid, st == 3);
      check("w_done", w_done, done_m);
      if (st == 3) begin
        check("tdata", tdata, m_phase(INC, beats));
        check("tlast", tlast, (beats % NSIG) == NSIG - 1);
        check("w_tdata", w_tdata, m_phase(INC_W, beats));
        check("w_tlast", w_tlast, (beats % NSIG) == NSIG - 1);
      end
    end
  end

  logic [23:0] beats_q[$];
  logic [23:0] wbeats_q[$];
  int done_cnt = 0, gpio_hi = 0, valid_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (tvalid && tready)   beats_q.push_back(tdata);
      if (w_tvalid && tready) wbeats_q.push_back(w_tdata);
      if (done)                done_cnt  <= done_cnt + 1;
      if (gpio_out == 12'h004) gpio_hi   <= gpio_hi + 1;
      if (tvalid)              valid_cyc <= valid_cyc + 1;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    check(nm, got, 1);
  endtask

  task automatic check_beats(input string nm, input int base);
    check($sformatf("%s_count", nm), beats_q.size() - base, TOTAL);
    for (int i = 0; i < TOTAL; i++)
      if (base + i < beats_q.size())
        check($sformatf("%s_beat%0d", nm, i), beats_q[base + i], EXP_B[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int bb, wb, dc, gh, vc, lat;
    reset = 1'b1; start = 1'b0; gpio_in = '0; tready = 1'b1;
    #3 reset = 1'b0;
    #14;
    check("rst_state", tx_state, 0);
    check("rst_busy", busy, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_gpio_out", gpio_out, 0);
    check("gpio_ddr", gpio_ddr, 12'h004);
    @(posedge clk); #2 reset = 1'b1;

    // Basic burst with acknowledge present
    gpio_in = 12'h001;
    repeat (4) @(posedge clk);
    #2;
    bb = beats_q.size(); wb = wbeats_q.size(); dc = done_cnt; gh = gpio_hi;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); lat++;
      if (tvalid) break;
    end
    check("latency", lat, 2 * N + 1);
    wait_done("basic_done_seen", 100);
    @(negedge clk);
    check_beats("basic", bb);
    for (int i = 0; i < 4; i++)
      if (wb + i < wbeats_q.size())
        check($sformatf("wrap_beat%0d", i), wbeats_q[wb + i], EXP_W[i]);
    check("basic_gpio_cycles", gpio_hi - gh, N);
    check("basic_done_count", done_cnt - dc, 1);
    check("basic_sync_err", sync_err, 0);

    // No acknowledge, then a clean retry
    gpio_in = 12'h000;
    repeat (4) @(posedge clk);
    #2 gh = gpio_hi; vc = valid_cyc;
    pulse_start();
    repeat (20) @(negedge clk);
    check("noack_sync_err", sync_err, 1);
    check("noack_busy", busy, 0);
    check("noack_valid_cycles", valid_cyc - vc, 0);
    check("noack_gpio_cycles", gpio_hi - gh, N);
    gpio_in = 12'h001;
    repeat (4) @(posedge clk);
    #2 bb = beats_q.size();
    pulse_start();
    repeat (2) @(negedge clk);
    check("retry_sync_err_cleared", sync_err, 0);
    wait_done("retry_done_seen", 100);
    @(negedge clk);
    check_beats("retry", bb);

    // Backpressure
    @(posedge clk); #2 bb = beats_q.size(); dc = done_cnt;
    pulse_start();
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 600; i++) begin
        @(posedge clk); #2 tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (done) begin got = 1; break; end
      end
      check("bp_done_seen", got, 1);
    end
    @(posedge clk); #2 tready = 1'b1;
    @(negedge clk);
    check_beats("bp", bb);
    check("bp_done_count", done_cnt - dc, 1);

    // Mid-burst reset while the 6th beat is presented
    pulse_start();
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (active && el > 2 * N && beats == 5) begin got = 1; break; end
      end
      check("midrst_reached", got, 1);
    end
    #1 reset = 1'b0;
    #1;
    check("midrst_tvalid", tvalid, 0);
    check("midrst_tdata", tdata, 0);
    check("midrst_tlast", tlast, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", tx_state, 0);
    check("midrst_symb", symb_idx, 0);
    check("midrst_w_tvalid", w_tvalid, 0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (4) @(posedge clk);
    #2 bb = beats_q.size();
    pulse_start();
    wait_done("midrst_done_seen", 100);
    @(negedge clk);
    check_beats("after_rst", bb);

    // Start pulses during GUARD and STREAM are ignored
    @(posedge clk); #2 bb = beats_q.size(); dc = done_cnt;
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    repeat (8) @(negedge clk);
    pulse_start();
    wait_done("busy_done_seen", 100);
    repeat (40) @(negedge clk);
    check_beats("busy_start", bb);
    check("busy_done_count", done_cnt - dc, 1);
    check("busy_idle_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_anc_sync_gen.md
Name: tx_anc_sync_gen

Overview:
- Transmit-side counterpart of the ANC receive controller.
- On a start request it drives the sync line on the front-panel GPIO, which is the receiver's trigger input, and checks that the receiver raises its acknowledge line in return.
- After a guard interval it streams DDS phase words over AXI-Stream: NSYMB symbols of NSIG samples each, with the tone frequency stepping every symbol.
- Output feeds the TX DDS/mixer chain.

Parameters:
- PHASE_WIDTH, 24, width of phase words and sample counter
- NSYMB_WIDTH, 16, width of the symbol counter
- NSYMB, 512, symbols per burst (>=1)
- NSIG, 16384, samples per symbol (>=1)
- START_PH, 0, phase value at the start of every symbol
- START_PH_INC, 4096, phase increment used for symbol 0
- DPH_INC, 16384, amount added to the phase increment at each symbol boundary
- SYNC_SIG_N, 8192, length in cycles of each of the SYNC and GUARD states
- GPIO_REG_WIDTH, 12, width of the GPIO bus
- SYNC_OUT_MASK, 12'h004, GPIO bit(s) driven as the sync line (the receiver's sync input)
- ACK_IN_MASK, 12'h001, GPIO bit(s) read as the receiver acknowledge (the receiver's sync output)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a burst; honoured only in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the last beat of the burst is accepted
- sync_err  out  1  sticky flag: no acknowledge seen during SYNC; cleared by the next accepted start
- gpio_in  in  GPIO_REG_WIDTH  front-panel GPIO inputs
- gpio_out  out  GPIO_REG_WIDTH  front-panel GPIO outputs
- gpio_ddr  out  GPIO_REG_WIDTH  direction register, constant SYNC_OUT_MASK
- phase_tdata  out  PHASE_WIDTH  DDS phase word
- phase_tvalid  out  1  AXI-S valid
- phase_tready  in  1  AXI-S ready
- phase_tlast  out  1  high on the last sample of each symbol
- tx_state  out  2  current state (debug)
- symb_idx  out  NSYMB_WIDTH  0-based index of the current symbol (debug)

Behaviour:
- Reset values: state IDLE (00); busy=0, done=0, sync_err=0; gpio_out=0; phase_tvalid=0; phase_tdata=START_PH; phase_tlast=0; symb_idx=0; ph_inc=START_PH_INC; all counters 0.
- States: IDLE=00, SYNC=01, GUARD=10, STREAM=11. All outputs are registered.
- IDLE:
  - start=1 moves to SYNC on the next edge.
  - On that transition: clear sync_err, sync_cnt<=1, ack_seen<=0.
  - start in any other state is ignored.
- SYNC:
  - gpio_out = SYNC_OUT_MASK.
  - ack_seen is set once any bit of (gpio_in_q & ACK_IN_MASK) is 1; gpio_in_q is gpio_in after one register stage.
  - At sync_cnt==SYNC_SIG_N: go to GUARD if ack_seen, or if an acknowledge is sampled in that same final cycle.
  - Otherwise go to IDLE with sync_err<=1.
  - Otherwise sync_cnt increments. The state therefore lasts exactly SYNC_SIG_N cycles.
- GUARD:
  - gpio_out=0, phase_tvalid=0.
  - Lasts exactly SYNC_SIG_N cycles, matching the receiver's filter-reload and settling window.
  - Then goes to STREAM with phase_tdata=START_PH, ph_inc=START_PH_INC, samp_cnt=1, symb_idx=0.
- STREAM:
  - phase_tvalid=1; phase_tlast=(samp_cnt==NSIG).
  - tdata, tlast and all counters hold while tvalid & !tready.
  - On each accepted beat that is not tlast: phase_tdata <= phase_tdata + ph_inc, modulo 2^PHASE_WIDTH (wrap-around is silent); samp_cnt++.
  - On an accepted tlast beat with symb_idx < NSYMB-1: phase_tdata<=START_PH, ph_inc<=ph_inc+DPH_INC (modulo), symb_idx++, samp_cnt<=1.
  - On an accepted tlast beat with symb_idx==NSYMB-1: done=1 for one cycle, phase_tvalid<=0, return to IDLE, ph_inc and symb_idx reset to their initial values.
  - NSIG=1 makes every beat a tlast beat.
- Latency: first valid beat appears 2*SYNC_SIG_N+1 cycles after start is sampled.
- Reset asserted mid-burst returns everything to reset values immediately (asynchronous). tvalid drops without waiting for a handshake.

Optional Feature:
- Macro TX_ANC_GPIO_SYNC_FF_EN.
- Defined: gpio_in passes through a two-flop synchronizer before the gpio_in_q register. Acknowledge detection latency is 3 cycles.
- Undefined: single register stage only, latency 1 cycle.
- The SYNC window length is unchanged either way. An acknowledge arriving in the last 2 cycles of SYNC is missed when the macro is defined.

Test Plan:
- Basic burst. Params NSYMB=3, NSIG=4, SYNC_SIG_N=8, START_PH_INC=100, DPH_INC=50. gpio_in ack bit tied 1, tready=1. Pulse start.
  -> gpio_out=12'h004 for exactly 8 cycles, then 8 idle cycles.
  -> Phases 0,100,200,300 | 0,150,300,450 | 0,200,400,600.
  -> tlast on the 4th, 8th and 12th beats; done one cycle after the 12th beat; sync_err=0.
- No acknowledge. Ack held 0.
  -> After 8 SYNC cycles: state IDLE, sync_err=1, no tvalid.
  -> A second start with ack=1 clears sync_err and streams normally.
- Backpressure. Toggle tready randomly during STREAM.
  -> Identical beat sequence to the basic burst; tdata and tlast stable while tvalid & !tready.
- Wrap. Set START_PH_INC=24'hC00000.
  -> Symbol 0 phases 0, C00000, 800000, 400000.
- Mid-burst reset. Assert reset at the 6th beat.
  -> All outputs return to reset values in the same cycle.
  -> A new start yields the full 12-beat sequence from phase 0.
- Start while busy. Pulse start during GUARD and during STREAM.
  -> Ignored; the sequence is unchanged and exactly one done pulse occurs.
